// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared states, op encodings and cycle constants for the mul/div sequencer
package muldiv_pkg;

   localparam int CNT_W           = 6;
   localparam int DEF_DIV_CYCLES  = 32;
   localparam int DEF_MULT_CYCLES = 32;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      WRITE,
      EXC
   } state_t;

   // Counter preload so that RUN lasts exactly `cycles` cycles (counts N-1 down to 0).
   function automatic logic [CNT_W-1:0] run_preload(input int cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/muldiv_cycle_cnt.sv
// rtl/muldiv_cycle_cnt.sv - loadable down-counter with zero flag timing the RUN phase
module muldiv_cycle_cnt
   import muldiv_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // Holds at zero rather than wrapping, so a late decrement is harmless.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - multiply/divide sequencing FSM; abort support under MULDIV_ABORT_EN
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int MULT_CYCLES = DEF_MULT_CYCLES
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_start,
   input  logic        op_sel,
   input  logic [31:0] srcB,
   input  logic        abort,
   output logic        div_init,
   output logic        mult_init,
   output logic        busy,
   output logic        stall,
   output logic        hilo_we,
   output logic        done,
   output logic        div_zero
);

   localparam logic [CNT_W-1:0] DIV_PRELOAD  = run_preload(DIV_CYCLES);
   localparam logic [CNT_W-1:0] MULT_PRELOAD = run_preload(MULT_CYCLES);

   state_t state;
   state_t state_nxt;
   logic   op_q;
   logic   cnt_zero;
   logic   run_phase;
   logic   abort_req;
   logic   div_by_zero;

`ifdef MULDIV_ABORT_EN
   assign abort_req = abort;
`else
   logic unused_abort;
   assign unused_abort = abort;
   assign abort_req    = 1'b0;
`endif

   assign div_by_zero = (op_sel == OP_DIV) && (srcB == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Operation type is captured only on an accepted request; later op_sel changes are ignored.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q <= OP_MULT;
      end else if ((state == IDLE) && op_start) begin
         op_q <= op_sel;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (op_start) state_nxt = div_by_zero ? EXC : LOAD;
         LOAD:    state_nxt = RUN;
         RUN:     if (cnt_zero) state_nxt = WRITE;
         WRITE:   state_nxt = IDLE;
         EXC:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // Abort takes priority over counter expiry in the same cycle.
      if (abort_req && ((state == LOAD) || (state == RUN))) begin
         state_nxt = IDLE;
      end
   end

   always_comb begin
      div_init  = 1'b0;
      mult_init = 1'b0;
      busy      = 1'b1;
      hilo_we   = 1'b0;
      done      = 1'b0;
      div_zero  = 1'b0;
      run_phase = 1'b0;
      case (state)
         IDLE:  busy = 1'b0;
         LOAD: begin
            run_phase = 1'b1;
            div_init  = (op_q == OP_DIV);
            mult_init = (op_q == OP_MULT);
         end
         RUN:   run_phase = 1'b1;
         WRITE: begin
            hilo_we = 1'b1;
            done    = 1'b1;
         end
         EXC:   div_zero = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   // Stall covers the request cycle itself, before the FSM has left IDLE.
   assign stall = reset & (op_start | run_phase);

   muldiv_cycle_cnt u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (state == LOAD),
      .load_val ((op_q == OP_DIV) ? DIV_PRELOAD : MULT_PRELOAD),
      .dec      (state == RUN),
      .zero     (cnt_zero)
   );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl against an event-level reference model
module tb_muldiv_ctrl;

   localparam int DIVN  = 32;
   localparam int MULTN = 4;
   localparam int BIG   = 1 << 30;

   localparam logic [4:0] EV_DIVINIT  = 5'b10000;
   localparam logic [4:0] EV_MULTINIT = 5'b01000;
   localparam logic [4:0] EV_WRITE    = 5'b00110;
   localparam logic [4:0] EV_EXC      = 5'b00001;

   typedef struct {
      int         cyc;
      logic [4:0] code;
   } ev_t;

   logic        clk;
   logic        reset;
   logic        op_start;
   logic        op_sel;
   logic [31:0] srcB;
   logic        abort;
   logic        div_init;
   logic        mult_init;
   logic        busy;
   logic        stall;
   logic        hilo_we;
   logic        done;
   logic        div_zero;

   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;
   ev_t q[$];
   int  m_start = BIG;
   int  m_end = -1;
   int  m_run_end = -1;
   bit  m_exc = 1'b0;

   muldiv_ctrl #(.DIV_CYCLES(DIVN), .MULT_CYCLES(MULTN)) dut (
      .clk       (clk),
      .reset     (reset),
      .op_start  (op_start),
      .op_sel    (op_sel),
      .srcB      (srcB),
      .abort     (abort),
      .div_init  (div_init),
      .mult_init (mult_init),
      .busy      (busy),
      .stall     (stall),
      .hilo_we   (hilo_we),
      .done      (done),
      .div_zero  (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
      end
   endtask

   // One clock of stimulus; the model is updated from the operation-level rules.
   task automatic step(input logic rs, input logic st, input logic sel,
                       input logic [31:0] b, input logic ab);
      ev_t keep[$];
      int  n;
      @(posedge clk);
      #1;
      reset = rs; op_start = st; op_sel = sel; srcB = b; abort = ab;
      if (!rs) begin
         q.delete();
         m_start = BIG; m_end = -1; m_run_end = -1; m_exc = 1'b0;
      end else begin
         if (st && (cyc > m_end)) begin
            m_start = cyc + 1;
            if (sel && (b == 32'd0)) begin
               m_exc = 1'b1;
               m_end = cyc + 1;
               m_run_end = -1;
               q.push_back('{cyc + 1, EV_EXC});
            end else begin
               m_exc = 1'b0;
               n = sel ? DIVN : MULTN;
               m_end = cyc + n + 2;
               m_run_end = m_end - 1;
               q.push_back('{cyc + 1, sel ? EV_DIVINIT : EV_MULTINIT});
               q.push_back('{m_end, EV_WRITE});
            end
         end
`ifdef MULDIV_ABORT_EN
         if (ab && !m_exc && (cyc >= m_start) && (cyc <= m_run_end) && (cyc <= m_end)) begin
            foreach (q[i]) if (q[i].cyc <= cyc) keep.push_back(q[i]);
            q = keep;
            m_end = cyc;
         end
`endif
      end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, 1'($urandom), $urandom, 1'b0);
   endtask

   task automatic wait_idle();
      for (int i = 0; (i < 100) && (cyc <= m_end); i++) idle(1);
   endtask

   always @(negedge clk) begin
      logic [4:0] code;
      code = {div_init, mult_init, hilo_we, done, div_zero};
      while ((q.size() > 0) && (q[0].cyc < cyc)) begin
         check("missed_event", 0, int'(q[0].code));
         void'(q.pop_front());
      end
      if (code != 5'd0) begin
         if ((q.size() > 0) && (q[0].cyc == cyc)) begin
            check("event", int'(code), int'(q[0].code));
            void'(q.pop_front());
         end else begin
            check("unexpected_event", int'(code), 0);
         end
      end
      check("busy", int'(busy), int'(reset && (cyc >= m_start) && (cyc <= m_end)));
      check("stall", int'(stall), int'(reset && (op_start ||
            (!m_exc && (cyc >= m_start) && (cyc <= m_end) && (cyc <= m_run_end)))));
   end

   initial begin
      #200000;
      $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
      $fatal(1);
   end

   initial begin
      int c;
      reset = 1'b1; op_start = 1'b0; op_sel = 1'b0; srcB = 32'd0; abort = 1'b0;
      #1 reset = 1'b0;
      repeat (3) step(1'b0, 1'b1, 1'b1, 32'd7, 1'b0);

      // Divide accepted on the first edge after reset release, with a stray request mid-run.
      step(1'b1, 1'b1, 1'b1, 32'd7, 1'b0);
      c = cyc;
      idle(9);
      step(1'b1, 1'b1, 1'b0, 32'd5, 1'b0);
      wait_idle();

      // Divide by zero, then multiplies including a zero multiplier.
      step(1'b1, 1'b1, 1'b1, 32'd0, 1'b0);
      wait_idle();
      step(1'b1, 1'b1, 1'b0, 32'd9, 1'b0);
      wait_idle();
      step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0);
      wait_idle();

      // Reset in the middle of a divide.
      step(1'b1, 1'b1, 1'b1, 32'd3, 1'b0);
      idle(14);
      step(1'b0, 1'b1, 1'b1, 32'd3, 1'b0);
      #1;
      check("async_reset_outputs",
            int'({busy, stall, div_init, mult_init, hilo_we, done, div_zero}), 0);
      step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      idle(2);

      // Abort request at cycle 20 of a divide.
      step(1'b1, 1'b1, 1'b1, 32'd11, 1'b0);
      c = cyc;
      idle(19);
      step(1'b1, 1'b0, 1'b0, 32'd0, 1'b1);
      check("abort_cycle", cyc - c, 20);
      wait_idle();

      for (int i = 0; i < 1500; i++) begin
         step(1'b1, ($urandom_range(0, 5) == 0), 1'($urandom),
              ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom,
              ($urandom_range(0, 40) == 0));
      end

      wait_idle();
      idle(3);
      check("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
